// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU operation codes, write flag and the
// operand-select encodings used by the EX-side operand network.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_operation_t;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } flag_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_IMM  = 2'd2,
    A_ZERO = 2'd3
  } a_sel_t;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: hazard controls, decoded fields, MEM/WB forwarding
// sources and the operands/controls handed on to the ALU.
interface id_ex_stage_if import id_ex_stage_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) ();

  logic                      stall;
  logic                      flush;

  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  alu_operation_t            id_alu_op;
  a_sel_t                    id_a_sel;
  b_sel_t                    id_b_sel;
  flag_t                     id_reg_write;

  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  flag_t                     mem_reg_write;
  flag_t                     wb_reg_write;
  logic [DATA_WIDTH-1:0]     mem_result;
  logic [DATA_WIDTH-1:0]     wb_result;

  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     bus_a;
  logic [DATA_WIDTH-1:0]     bus_b;
  alu_operation_t            opSel;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  flag_t                     ex_reg_write;
  logic [DATA_WIDTH-1:0]     ex_pc;

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1_addr, id_rs2_addr, id_rd_addr,
    output id_alu_op, id_a_sel, id_b_sel, id_reg_write,
    output mem_rd_addr, wb_rd_addr, mem_reg_write, wb_reg_write,
    output mem_result, wb_result,
    input  ex_valid, bus_a, bus_b, opSel, ex_store_data,
    input  ex_rd_addr, ex_reg_write, ex_pc
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1_addr, id_rs2_addr, id_rd_addr,
    input  id_alu_op, id_a_sel, id_b_sel, id_reg_write,
    input  mem_rd_addr, wb_rd_addr, mem_reg_write, wb_reg_write,
    input  mem_result, wb_result,
    output ex_valid, bus_a, bus_b, opSel, ex_store_data,
    output ex_rd_addr, ex_reg_write, ex_pc
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding select for one source operand: MEM beats WB beats the stored
// register value, and x0 is never forwarded.
module id_ex_stage_fwd_mux import id_ex_stage_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  flag_t                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  flag_t                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  logic rs_nonzero_s;
  logic mem_hit_s;
  logic wb_hit_s;

  assign rs_nonzero_s = (rs_addr != {REG_ADDR_WIDTH{1'b0}});
  assign mem_hit_s    = (mem_reg_write == HIGH) && (mem_rd_addr == rs_addr) && rs_nonzero_s;
  assign wb_hit_s     = (wb_reg_write == HIGH) && (wb_rd_addr == rs_addr) && rs_nonzero_s;

  // Priority select of the operand source.
  always_comb begin
    fwd_data = rs_data;
    if (mem_hit_s) begin
      fwd_data = mem_result;
    end else if (wb_hit_s) begin
      fwd_data = wb_result;
    end else begin
      fwd_data = rs_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush handling and the forwarding and
// operand-select network that feeds the ALU.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave pipe
);

  logic                      valid_r;
  logic [DATA_WIDTH-1:0]     pc_r;
  logic [DATA_WIDTH-1:0]     rs1_data_r;
  logic [DATA_WIDTH-1:0]     rs2_data_r;
  logic [DATA_WIDTH-1:0]     imm_r;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_r;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_r;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
  alu_operation_t            alu_op_r;
  a_sel_t                    a_sel_r;
  b_sel_t                    b_sel_r;
  flag_t                     reg_write_r;

  logic                      rs1_wb_hit_s;
  logic                      rs2_wb_hit_s;
  logic [DATA_WIDTH-1:0]     fwd_rs1_s;
  logic [DATA_WIDTH-1:0]     fwd_rs2_s;
  logic [DATA_WIDTH-1:0]     bus_a_s;
  logic [DATA_WIDTH-1:0]     bus_b_s;

  // A WB retirement during a stall is folded into the held operand, otherwise
  // it would be gone by the time the stall releases.
  assign rs1_wb_hit_s = (pipe.wb_reg_write == HIGH) &&
                        (pipe.wb_rd_addr != {REG_ADDR_WIDTH{1'b0}}) &&
                        (pipe.wb_rd_addr == rs1_addr_r);
  assign rs2_wb_hit_s = (pipe.wb_reg_write == HIGH) &&
                        (pipe.wb_rd_addr != {REG_ADDR_WIDTH{1'b0}}) &&
                        (pipe.wb_rd_addr == rs2_addr_r);

  // EX-stage state: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      pc_r        <= {DATA_WIDTH{1'b0}};
      rs1_data_r  <= {DATA_WIDTH{1'b0}};
      rs2_data_r  <= {DATA_WIDTH{1'b0}};
      imm_r       <= {DATA_WIDTH{1'b0}};
      rs1_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
      rs2_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
      rd_addr_r   <= {REG_ADDR_WIDTH{1'b0}};
      alu_op_r    <= ALU_ADD;
      a_sel_r     <= A_ZERO;
      b_sel_r     <= B_IMM;
      reg_write_r <= LOW;
    end else if (pipe.flush) begin
      valid_r     <= 1'b0;
      reg_write_r <= LOW;
      alu_op_r    <= ALU_ADD;
    end else if (pipe.stall) begin
      if (rs1_wb_hit_s) begin
        rs1_data_r <= pipe.wb_result;
      end
      if (rs2_wb_hit_s) begin
        rs2_data_r <= pipe.wb_result;
      end
    end else begin
      valid_r     <= pipe.id_valid;
      pc_r        <= pipe.id_pc;
      rs1_data_r  <= pipe.id_rs1_data;
      rs2_data_r  <= pipe.id_rs2_data;
      imm_r       <= pipe.id_imm;
      rs1_addr_r  <= pipe.id_rs1_addr;
      rs2_addr_r  <= pipe.id_rs2_addr;
      rd_addr_r   <= pipe.id_rd_addr;
      alu_op_r    <= pipe.id_alu_op;
      a_sel_r     <= pipe.id_a_sel;
      b_sel_r     <= pipe.id_b_sel;
      reg_write_r <= pipe.id_reg_write;
    end
  end

  id_ex_stage_fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .rs_addr       (rs1_addr_r),
    .rs_data       (rs1_data_r),
    .mem_rd_addr   (pipe.mem_rd_addr),
    .mem_reg_write (pipe.mem_reg_write),
    .mem_result    (pipe.mem_result),
    .wb_rd_addr    (pipe.wb_rd_addr),
    .wb_reg_write  (pipe.wb_reg_write),
    .wb_result     (pipe.wb_result),
    .fwd_data      (fwd_rs1_s)
  );

  id_ex_stage_fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .rs_addr       (rs2_addr_r),
    .rs_data       (rs2_data_r),
    .mem_rd_addr   (pipe.mem_rd_addr),
    .mem_reg_write (pipe.mem_reg_write),
    .mem_result    (pipe.mem_result),
    .wb_rd_addr    (pipe.wb_rd_addr),
    .wb_reg_write  (pipe.wb_reg_write),
    .wb_result     (pipe.wb_result),
    .fwd_data      (fwd_rs2_s)
  );

  // ALU operand A select.
  always_comb begin
    bus_a_s = {DATA_WIDTH{1'b0}};
    case (a_sel_r)
      A_RS1:   bus_a_s = fwd_rs1_s;
      A_PC:    bus_a_s = pc_r;
      A_IMM:   bus_a_s = imm_r;
      A_ZERO:  bus_a_s = {DATA_WIDTH{1'b0}};
      default: bus_a_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // ALU operand B select; the unused encoding yields zero.
  always_comb begin
    bus_b_s = {DATA_WIDTH{1'b0}};
    case (b_sel_r)
      B_RS2:   bus_b_s = fwd_rs2_s;
      B_IMM:   bus_b_s = imm_r;
      B_FOUR:  bus_b_s = {{(DATA_WIDTH-3){1'b0}}, 3'd4};
      default: bus_b_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign pipe.ex_valid      = valid_r;
  assign pipe.bus_a         = bus_a_s;
  assign pipe.bus_b         = bus_b_s;
  assign pipe.opSel         = alu_op_r;
  assign pipe.ex_store_data = fwd_rs2_s;
  assign pipe.ex_rd_addr    = rd_addr_r;
  assign pipe.ex_reg_write  = (valid_r && (reg_write_r == HIGH)) ? HIGH : LOW;
  assign pipe.ex_pc         = pc_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, x0 guard,
// stall capture of WB results and flush-over-stall.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) pipe ();

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic no_fwd();
    pipe.mem_reg_write = LOW;
    pipe.wb_reg_write  = LOW;
    pipe.mem_rd_addr   = 5'd0;
    pipe.wb_rd_addr    = 5'd0;
    pipe.mem_result    = 32'd0;
    pipe.wb_result     = 32'd0;
  endtask

  task automatic load_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                            input a_sel_t asel, input b_sel_t bsel, input alu_operation_t op);
    pipe.id_valid     = 1'b1;
    pipe.id_pc        = pc;
    pipe.id_rs1_addr  = rs1;
    pipe.id_rs1_data  = d1;
    pipe.id_rs2_addr  = rs2;
    pipe.id_rs2_data  = d2;
    pipe.id_imm       = imm;
    pipe.id_a_sel     = asel;
    pipe.id_b_sel     = bsel;
    pipe.id_alu_op    = op;
    pipe.id_rd_addr   = 5'd2;
    pipe.id_reg_write = HIGH;
  endtask

  initial begin
    rst        = 1'b1;
    pipe.stall = 1'b0;
    pipe.flush = 1'b0;
    no_fwd();
    load_instr(32'h40, 5'd1, 32'd5, 5'd6, 32'd3, 32'h77, A_RS1, B_IMM, ALU_SUB);

    // Reset held two cycles with a valid instruction presented.
    cycle();
    cycle();
    chk("rst_valid", 32'(pipe.ex_valid), 32'd0);
    chk("rst_rw",    32'(pipe.ex_reg_write), 32'd0);
    chk("rst_op",    32'(pipe.opSel), 32'(ALU_ADD));
    chk("rst_bus_a", pipe.bus_a, 32'd0);
    chk("rst_bus_b", pipe.bus_b, 32'd0);

    // Plain load.
    rst = 1'b0;
    load_instr(32'h40, 5'd1, 32'd5, 5'd6, 32'd3, 32'd7, A_RS1, B_IMM, ALU_ADD);
    cycle();
    chk("ld_bus_a", pipe.bus_a, 32'd5);
    chk("ld_bus_b", pipe.bus_b, 32'd7);
    chk("ld_op",    32'(pipe.opSel), 32'(ALU_ADD));
    chk("ld_valid", 32'(pipe.ex_valid), 32'd1);
    chk("ld_rw",    32'(pipe.ex_reg_write), 32'd1);
    chk("ld_rd",    32'(pipe.ex_rd_addr), 32'd2);
    chk("ld_pc",    pipe.ex_pc, 32'h40);

    // Forwarding priority on rs1=x3 / rs2=x5.
    load_instr(32'h44, 5'd3, 32'h11, 5'd5, 32'h22, 32'd0, A_RS1, B_RS2, ALU_OR);
    cycle();
    pipe.mem_rd_addr = 5'd3; pipe.mem_result = 32'hAA; pipe.mem_reg_write = HIGH;
    pipe.wb_rd_addr  = 5'd3; pipe.wb_result  = 32'hBB; pipe.wb_reg_write  = HIGH;
    #1;
    chk("fwd_mem_a",  pipe.bus_a, 32'hAA);
    chk("fwd_none_b", pipe.bus_b, 32'h22);
    pipe.mem_reg_write = LOW;
    #1;
    chk("fwd_wb_a", pipe.bus_a, 32'hBB);
    pipe.wb_reg_write = LOW;
    #1;
    chk("fwd_reg_a", pipe.bus_a, 32'h11);
    pipe.mem_rd_addr = 5'd5; pipe.mem_result = 32'h33; pipe.mem_reg_write = HIGH;
    #1;
    chk("fwd_mem_b",  pipe.bus_b, 32'h33);
    chk("fwd_store",  pipe.ex_store_data, 32'h33);
    no_fwd();

    // x0 must never be forwarded.
    load_instr(32'h48, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, A_RS1, B_RS2, ALU_ADD);
    cycle();
    pipe.mem_rd_addr = 5'd0; pipe.mem_result = 32'h55; pipe.mem_reg_write = HIGH;
    pipe.wb_rd_addr  = 5'd0; pipe.wb_result  = 32'h66; pipe.wb_reg_write  = HIGH;
    #1;
    chk("x0_bus_a", pipe.bus_a, 32'd0);
    chk("x0_bus_b", pipe.bus_b, 32'd0);
    no_fwd();

    // Stall capture of a WB result into the held rs2 register.
    load_instr(32'h4C, 5'd7, 32'h70, 5'd4, 32'd1, 32'd0, A_ZERO, B_RS2, ALU_SUB);
    cycle();
    chk("st_pre_b", pipe.bus_b, 32'd1);
    pipe.stall = 1'b1;
    pipe.id_rs2_data = 32'hDEAD;
    pipe.id_valid    = 1'b0;
    pipe.wb_rd_addr = 5'd4; pipe.wb_result = 32'd9; pipe.wb_reg_write = HIGH;
    #1;
    chk("st_fwd_b", pipe.bus_b, 32'd9);
    cycle();
    no_fwd();
    #1;
    chk("st_c1_b",     pipe.bus_b, 32'd9);
    chk("st_c1_valid", 32'(pipe.ex_valid), 32'd1);
    chk("st_c1_op",    32'(pipe.opSel), 32'(ALU_SUB));
    cycle();
    chk("st_c2_b", pipe.bus_b, 32'd9);
    pipe.stall = 1'b0;
    #1;
    chk("st_rel_b", pipe.bus_b, 32'd9);

    // Stall and flush together: the flush wins.
    pipe.stall = 1'b1;
    pipe.flush = 1'b1;
    pipe.id_valid = 1'b1;
    cycle();
    chk("fl_valid", 32'(pipe.ex_valid), 32'd0);
    chk("fl_rw",    32'(pipe.ex_reg_write), 32'd0);
    chk("fl_op",    32'(pipe.opSel), 32'(ALU_ADD));

    // JAL-style reload after the bubble.
    pipe.stall = 1'b0;
    pipe.flush = 1'b0;
    load_instr(32'h100, 5'd0, 32'd0, 5'd0, 32'd0, 32'h20, A_PC, B_FOUR, ALU_ADD);
    cycle();
    chk("jal_bus_a", pipe.bus_a, 32'h100);
    chk("jal_bus_b", pipe.bus_b, 32'd4);
    chk("jal_valid", 32'(pipe.ex_valid), 32'd1);
    chk("jal_rw",    32'(pipe.ex_reg_write), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
